// File: rtl/eth_tx_framer.sv
// rtl/eth_tx_framer.sv - RMII transmit framer: preamble/SFD, payload, zero pad, IFG
// Emits one dibit per clock, MSB pair of each byte first, from a one-byte hold register.
module eth_tx_framer #(
  parameter int PREAMBLE_BYTES = 7,
  parameter int MIN_BYTES      = 60,
  parameter int IFG_CYCLES     = 48
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       axiiv,
  input  logic [7:0] axiid,
  input  logic       axiilast,
  output logic       axiir,
  output logic       axiov,
  output logic [1:0] axiod,
  output logic       tx_busy,
  output logic       tx_err
);

  typedef enum logic [2:0] {S_IDLE, S_PREAMBLE, S_DATA, S_PAD, S_IFG} state_t;

  localparam logic [7:0]  PRE_N    = 8'(PREAMBLE_BYTES);
  localparam logic [7:0]  PRE_M1   = 8'(PREAMBLE_BYTES - 1);
  localparam logic [10:0] MIN_B    = 11'(MIN_BYTES);
  localparam logic [15:0] IFG_LAST = 16'(IFG_CYCLES - 1);

  state_t      state, next_state;
  logic        run, hold_full, hold_last, last_acc, cur_last;
  logic [7:0]  hold_data, sreg, pcnt, load_byte;
  logic [1:0]  dc;
  logic [10:0] bcnt;
  logic [15:0] ifg_cnt;
  logic        xfer, boundary, data_bnd;
  logic        load_en, take_hold, bump, stop, underrun, frame_done;

  // run keeps axiir low on the first cycle out of reset
  assign axiir = run && !last_acc && !hold_full &&
                 (state == S_IDLE || state == S_PREAMBLE || state == S_DATA);
  assign xfer     = axiiv && axiir;
  assign boundary = (dc == 2'd3);
  assign data_bnd = boundary && (state == S_DATA || (state == S_PREAMBLE && pcnt == PRE_N));

  always_comb begin
    next_state = state;
    load_en    = 1'b0;
    load_byte  = 8'h00;
    take_hold  = 1'b0;
    bump       = 1'b0;
    stop       = 1'b0;
    underrun   = 1'b0;
    frame_done = 1'b0;
    case (state)
      S_IDLE: begin
        if (xfer) begin
          load_en    = 1'b1;
          load_byte  = 8'h55;
          next_state = S_PREAMBLE;
        end
      end
      S_PREAMBLE, S_DATA: begin
        if (data_bnd) begin
          if (cur_last) begin
            if (bcnt < MIN_B) begin
              next_state = S_PAD;
              load_en    = 1'b1;
              bump       = 1'b1;
            end else begin
              next_state = S_IFG;
              stop       = 1'b1;
            end
          end else if (hold_full) begin
            next_state = S_DATA;
            load_en    = 1'b1;
            load_byte  = hold_data;
            take_hold  = 1'b1;
            bump       = 1'b1;
          end else begin
            next_state = S_IFG;
            stop       = 1'b1;
            underrun   = 1'b1;
          end
        end else if (boundary && state == S_PREAMBLE) begin
          load_en   = 1'b1;
          load_byte = (pcnt == PRE_M1) ? 8'hD5 : 8'h55;
        end
      end
      S_PAD: begin
        if (boundary) begin
          if (bcnt < MIN_B) begin
            load_en = 1'b1;
            bump    = 1'b1;
          end else begin
            next_state = S_IFG;
            stop       = 1'b1;
          end
        end
      end
      S_IFG: begin
        if (ifg_cnt == IFG_LAST) begin
          next_state = S_IDLE;
          frame_done = 1'b1;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      run       <= 1'b0;
      hold_full <= 1'b0;
      hold_last <= 1'b0;
      hold_data <= 8'h00;
      last_acc  <= 1'b0;
      cur_last  <= 1'b0;
      sreg      <= 8'h00;
      dc        <= 2'd0;
      pcnt      <= 8'h00;
      bcnt      <= 11'd0;
      ifg_cnt   <= 16'd0;
      axiov     <= 1'b0;
      axiod     <= 2'b00;
      tx_busy   <= 1'b0;
      tx_err    <= 1'b0;
    end else begin
      run    <= 1'b1;
      state  <= next_state;
      tx_err <= underrun;

      if (xfer) begin
        hold_data <= axiid;
        hold_last <= axiilast;
        hold_full <= 1'b1;
        if (axiilast) last_acc <= 1'b1;
      end else if (take_hold) begin
        hold_full <= 1'b0;
      end
      if (take_hold) cur_last <= hold_last;

      // A loaded byte shows its top dibit immediately; the rest shift out of sreg
      if (load_en) begin
        axiov <= 1'b1;
        axiod <= load_byte[7:6];
        sreg  <= {load_byte[5:0], 2'b00};
        dc    <= 2'd0;
      end else if (stop) begin
        axiov <= 1'b0;
        axiod <= 2'b00;
        dc    <= 2'd0;
      end else if (axiov) begin
        axiod <= sreg[7:6];
        sreg  <= {sreg[5:0], 2'b00};
        dc    <= dc + 2'd1;
      end

      if (state == S_IDLE && xfer) begin
        pcnt    <= 8'h00;
        tx_busy <= 1'b1;
      end else if (load_en && state == S_PREAMBLE && !take_hold) begin
        pcnt <= pcnt + 8'h01;
      end

      if (bump && bcnt != 11'h7FF) bcnt <= bcnt + 11'd1;

      if (stop) ifg_cnt <= 16'd1;
      else if (state == S_IFG) ifg_cnt <= ifg_cnt + 16'd1;

      if (frame_done) begin
        tx_busy  <= 1'b0;
        last_acc <= 1'b0;
        cur_last <= 1'b0;
        bcnt     <= 11'd0;
      end
    end
  end

endmodule

// File: tb/tb_eth_tx_framer.sv
// tb/tb_eth_tx_framer.sv - scoreboard bench for eth_tx_framer
module tb_eth_tx_framer;

  logic       clk = 1'b0;
  logic       rst_n, axiiv, axiilast;
  logic [7:0] axiid;
  logic       axiir, axiov, tx_busy, tx_err;
  logic [1:0] axiod;

  int tests_run = 0;
  int tests_failed = 0;

  logic [1:0] exp_q[$];
  int         hi_q[$];
  int         lo_q[$];
  int         hi_run = 0, lo_run = 0, have_hi = 0, prev_ov = 0;
  int         err_cnt = 0, ir_bad = 0;
  bit         tb_last_acc = 1'b0;

  eth_tx_framer dut (
    .clk(clk), .rst_n(rst_n), .axiiv(axiiv), .axiid(axiid), .axiilast(axiilast),
    .axiir(axiir), .axiov(axiov), .axiod(axiod), .tx_busy(tx_busy), .tx_err(tx_err)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    exp_q.push_back(b[7:6]);
    exp_q.push_back(b[5:4]);
    exp_q.push_back(b[3:2]);
    exp_q.push_back(b[1:0]);
  endtask

  task automatic push_frame(input int n, input int start, input bit last);
    for (int i = 0; i < 7; i++) push_byte(8'h55);
    push_byte(8'hD5);
    for (int i = 0; i < n; i++) push_byte(8'(start + i));
    if (last) for (int i = n; i < 60; i++) push_byte(8'h00);
  endtask

  task automatic send_bytes(input int n, input int start, input int gap, input bit last);
    for (int i = 0; i < n; i++) begin
      int t = 0;
      axiiv    = 1'b1;
      axiid    = 8'(start + i);
      axiilast = last && (i == n - 1);
      while (!axiir && t < 3000) begin
        @(negedge clk);
        t++;
      end
      if (t >= 3000) begin
        check("drv_timeout", t, 0);
        axiiv = 1'b0;
        axiilast = 1'b0;
        break;
      end
      @(negedge clk);
      if (axiilast) tb_last_acc = 1'b1;
      else if (i == 0) tb_last_acc = 1'b0;
      axiiv    = 1'b0;
      axiilast = 1'b0;
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((axiov || tx_busy) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check("idle_timeout", 32'(t < 5000), 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_hi(input string tag, input int exp);
    int v = -1;
    if (hi_q.size() > 0) v = hi_q.pop_front();
    check(tag, v, exp);
  endtask

  task automatic check_lo(input string tag, input int exp);
    int v = -1;
    if (lo_q.size() > 0) v = lo_q.pop_front();
    check(tag, v, exp);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      hi_run = 0; lo_run = 0; have_hi = 0; prev_ov = 0;
    end else begin
      if (axiov) begin
        logic [1:0] e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 2'bxx;
        check("dibit", {30'b0, axiod}, {30'b0, e});
        if (!prev_ov && have_hi != 0) lo_q.push_back(lo_run);
        hi_run++;
        lo_run = 0;
      end else begin
        if (prev_ov != 0) begin
          hi_q.push_back(hi_run);
          have_hi = 1;
        end
        hi_run = 0;
        lo_run++;
      end
      if (tx_err) begin
        err_cnt++;
        check("err_edge", (prev_ov << 1) | 32'(axiov), 2);
      end
      if (tb_last_acc && axiir && axiov) ir_bad++;
      prev_ov = 32'(axiov);
    end
  end

  initial begin
    int t;
    rst_n = 1'b0; axiiv = 1'b0; axiilast = 1'b0; axiid = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_axiov", 32'(axiov), 0);
    check("rst_axiod", 32'(axiod), 0);
    check("rst_axiir", 32'(axiir), 0);
    check("rst_busy", 32'(tx_busy), 0);
    check("rst_err", 32'(tx_err), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // short frame, padded to minimum
    push_frame(4, 8'h01, 1);
    send_bytes(4, 8'h01, 0, 1);
    check("busy_in_frame", 32'(tx_busy), 1);
    wait_idle();
    check_hi("short_len", 272);

    // 64-byte frame, no pad
    push_frame(64, 8'h00, 1);
    send_bytes(64, 8'h00, 0, 1);
    wait_idle();
    check_hi("long_len", 288);

    // underrun after 10 bytes, then a normal frame
    err_cnt = 0;
    push_frame(10, 8'h80, 0);
    send_bytes(10, 8'h80, 0, 0);
    t = 0;
    while (err_cnt == 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("err_seen", 32'(t < 500), 1);
    lo_q.delete();
    push_frame(4, 8'hA0, 1);
    send_bytes(4, 8'hA0, 0, 1);
    wait_idle();
    check("err_count", err_cnt, 1);
    check_hi("underrun_len", 72);
    check_hi("after_err_len", 272);
    check_lo("err_gap", 48);

    // back-to-back frames: second waits out pad and IFG
    ir_bad = 0;
    push_frame(5, 8'h10, 1);
    push_frame(3, 8'h20, 1);
    send_bytes(5, 8'h10, 0, 1);
    lo_q.delete();
    send_bytes(3, 8'h20, 0, 1);
    wait_idle();
    check_hi("b2b_len0", 272);
    check_hi("b2b_len1", 272);
    check_lo("b2b_gap", 48);
    check("ir_during_tail", ir_bad, 0);

    // reset in the middle of data
    push_frame(20, 8'h40, 0);
    send_bytes(20, 8'h40, 0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_axiov", 32'(axiov), 0);
    check("mid_rst_busy", 32'(tx_busy), 0);
    check("mid_rst_axiir", 32'(axiir), 0);
    rst_n = 1'b1;
    exp_q.delete();
    hi_q.delete();
    lo_q.delete();
    tb_last_acc = 1'b0;
    @(negedge clk);
    push_frame(60, 8'h90, 1);
    send_bytes(60, 8'h90, 0, 1);
    wait_idle();
    check_hi("post_rst_len", 272);

    // slow source: two idle cycles between bytes
    err_cnt = 0;
    push_frame(20, 8'h30, 1);
    send_bytes(20, 8'h30, 2, 1);
    wait_idle();
    check("slow_no_err", err_cnt, 0);
    check_hi("slow_len", 272);
    check("hi_extra", hi_q.size(), 0);

    check("sb_left", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
